// File: rtl/pulse_cdc_toggle_tx_pkg.sv
// Shared types and defaults for the toggle-based pulse CDC sender.
//   state_e        : sender FSM states
//   DEF_NUM_STAGES : default ack synchronizer depth
//   DEF_CNT_WIDTH  : default pending-event counter width
package pulse_cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_CNT_WIDTH  = 4;

endpackage

// File: rtl/pulse_cdc_toggle_tx_if.sv
// Handshake bundle between the event source / destination loopback and the
// pulse CDC sender.
//   pulse_in     : source-domain event strobe (one event per high cycle)
//   ack_toggle   : destination's registered copy of the received toggle (async)
//   clr_overflow : synchronous clear of the sticky overflow flag
//   toggle_out   : toggle level sent to the destination synchronizer
//   busy         : a crossing is awaiting acknowledge
//   pending      : queued, not-yet-launched events
//   overflow     : sticky flag, an event was dropped
interface pulse_cdc_toggle_tx_if
  import pulse_cdc_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 pulse_in;
  logic                 ack_toggle;
  logic                 clr_overflow;
  logic                 toggle_out;
  logic                 busy;
  logic [CNT_WIDTH-1:0] pending;
  logic                 overflow;

  modport master (
    output pulse_in, ack_toggle, clr_overflow,
    input  toggle_out, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, ack_toggle, clr_overflow,
    output toggle_out, busy, pending, overflow
  );

endinterface

// File: rtl/pulse_cdc_toggle_tx_sync.sv
// cdc_bit_sync: multi-flop level synchronizer with async active-high reset.
//   clk  : destination clock of the synchronizer
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : asynchronous input level
//   q_o  : synchronized level (last stage)
// NUM_STAGES must be at least 2.
module cdc_bit_sync
  import pulse_cdc_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  // Synchronizer chain must survive optimization and stay as discrete flops.
  (* keep = "true", dont_touch = "true", preserve = "true", async_reg = "true" *)
  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/pulse_cdc_toggle_tx.sv
// Source-domain sender for single-event clock-domain crossing. Each pulse_in
// high cycle is one event; events are launched one at a time as flips of
// toggle_out, and the next flip waits until the synchronized ack level matches.
// Events arriving during a crossing are queued in a saturating counter.
//   clk   : source-domain clock
//   reset : asynchronous active-high reset
//   bus   : handshake bundle (slave side), see pulse_cdc_toggle_tx_if
module pulse_cdc_toggle_tx
  import pulse_cdc_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  pulse_cdc_toggle_tx_if.slave   bus
);

  state_e               state_q;
  logic                 toggle_q;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 ack_s;
  logic                 launch;
  logic [CNT_WIDTH:0]   pend_sum;

  cdc_bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (reset),
    .d_i (bus.ack_toggle),
    .q_o (ack_s)
  );

  assign launch = (state_q == IDLE) && ((pending_q != '0) || bus.pulse_in);

  // Never underflows: launch implies pending!=0 or pulse_in. The carry bit
  // is set only when pending is full, a pulse arrives and nothing launches.
  assign pend_sum = {1'b0, pending_q}
                  + {{CNT_WIDTH{1'b0}}, bus.pulse_in}
                  - {{CNT_WIDTH{1'b0}}, launch};

  always_comb begin
    if (pend_sum[CNT_WIDTH]) begin
      pending_d  = pending_q;
      overflow_d = 1'b1;
    end else begin
      pending_d  = pend_sum[CNT_WIDTH-1:0];
      overflow_d = overflow_q & ~bus.clr_overflow;
    end
  end

  // Returning to IDLE never launches in the same cycle, so crossings are
  // always separated by at least one IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      toggle_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            toggle_q <= ~toggle_q;
            state_q  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == toggle_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.toggle_out = toggle_q;
  assign bus.busy       = (state_q == WAIT_ACK);
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;

endmodule
